// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } mau_state_e;

endpackage

// File: rtl/mau_byte_lane.sv
// Little-endian byte extract (sign/zero extend) and byte merge.
module mau_byte_lane
    import mau_pkg::*;
(
    input  logic [15:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic        sel_i,
    input  logic        sext_i,
    output logic [15:0] ext_o,
    output logic [15:0] merge_o
);

    logic [7:0] lane;

    always_comb begin
        lane = (sel_i == LANE_HI) ? word_i[15:8] : word_i[7:0];
        ext_o = {{8{sext_i & lane[7]}}, lane};
    end

    always_comb begin
        merge_o = word_i;
        if (sel_i == LANE_LO) begin
            merge_o[7:0] = byte_i;
        end else begin
            merge_o[15:8] = byte_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with registered memory outputs and read-modify-write byte stores.
// Optional word alignment checking is enabled with MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic          req_sext,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
);

    import mau_pkg::*;

    mau_state_e    state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          we_q, we_d;
    logic          byte_q, byte_d;
    logic          sext_q, sext_d;
    logic [7:0]    wbyte_q, wbyte_d;
    logic          err_q, err_d;
    logic          misaligned;
    logic [DW-1:0] lane_ext;
    logic [DW-1:0] lane_merge;

    mau_byte_lane u_lane (
        .word_i  (mem_rd),
        .byte_i  (wbyte_q),
        .sel_i   (mem_a_q[0]),
        .sext_i  (sext_q),
        .ext_o   (lane_ext),
        .merge_o (lane_merge)
    );

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned = !req_byte && req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_we_d   = 1'b0;
        mem_a_d    = mem_a_q;
        mem_wd_d   = mem_wd_q;
        rsp_data_d = rsp_data_q;
        we_d       = we_q;
        byte_d     = byte_q;
        sext_d     = sext_q;
        wbyte_d    = wbyte_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    byte_d     = req_byte;
                    sext_d     = req_sext;
                    wbyte_d    = req_wdata[7:0];
                    rsp_data_d = '0;
                    err_d      = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else if (req_we && !req_byte) begin
                        mem_a_d  = req_addr;
                        mem_wd_d = req_wdata;
                        mem_we_d = 1'b1;
                        state_d  = WR;
                    end else begin
                        mem_a_d = req_addr;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_wd_d = lane_merge;
                    mem_we_d = 1'b1;
                    state_d  = WR;
                end else begin
                    rsp_data_d = byte_q ? lane_ext : mem_rd;
                    state_d    = RSP;
                end
            end
            WR: begin
                state_d = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            rsp_data_q <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            sext_q     <= 1'b0;
            wbyte_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
            rsp_data_q <= rsp_data_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            sext_q     <= sext_d;
            wbyte_q    <= wbyte_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_data_q;
    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    assign mem_wd    = mem_wd_q;

`ifdef MAU_ALIGN_CHECK_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the execute stage and the 16-entry × 16-bit data memory. It accepts one load or store per handshake and drives registered, glitch-free address, write-data and write-enable signals to the memory. Byte stores are done as read-modify-write. It returns load data or a store acknowledge on a response handshake to the write-back stage.

## Interface
Parameters:
- AW, 16, address width (byte address; memory word index is addr[AW-1:1])
- DW, 16, data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_sext  in  1  byte load: 1 = sign-extend, 0 = zero-extend
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data (byte store uses [7:0])
- mem_we  out  1  memory write enable (registered)
- mem_a  out  AW  memory address (registered)
- mem_wd  out  DW  memory write data (registered)
- mem_rd  in  DW  memory read data (combinational from mem_a)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DW  load result; 0 for stores
- rsp_err  out  1  misaligned access (ALIGN_CHECK_EN builds only)

## Operation
- FSM states: IDLE, RD, WR, RSP. The unit holds one request at a time.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and load mem_a=req_addr.
  - Misaligned request (see Configuration): go to RSP with rsp_err=1.
  - Word store: mem_wd=req_wdata, mem_we=1, go to WR.
  - Any other request: go to RD.
- RD:
  - Sample mem_rd at the end of the cycle.
  - Load: go to RSP.
  - Byte store: merge the byte into the read word, set mem_we=1, go to WR.
- WR: mem_we is high for exactly this one cycle; it clears on exit. Go to RSP.
- RSP: rsp_valid=1 and held stable until rsp_ready; then go to IDLE. req_ready=0 in every state except IDLE.
- Byte lanes, little-endian:
  - addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
  - Byte load result is {8{sext & byte[7]}, byte}.
  - Byte-store merge replaces only the selected lane.
- Word load: rsp_data=mem_rd as sampled in RD.

## Timing
- Request accepted at edge 0. rsp_valid rises after:
  - word load: edge 2
  - word store: edge 2
  - byte load: edge 2
  - byte store: edge 3
  - misaligned: edge 1
- mem_we is never high for more than one consecutive cycle per request. mem_a and mem_wd are stable whenever mem_we=1.
- Throughput: with rsp_ready tied high, one request per 3 cycles (4 for a byte store).
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready. req_ready=0 while rst_n=0 and 1 after release.
  - Any in-flight request is dropped with no response. A write already in WR is cut off by mem_we clearing.
- req_valid in a non-IDLE state is ignored; the upstream stage must hold it.

## Configuration
- MAU_ALIGN_CHECK_EN defined:
  - A word access with addr[0]=1 produces no memory activity.
  - The response is rsp_err=1, rsp_data=0.
- MAU_ALIGN_CHECK_EN undefined:
  - addr[0] is ignored for word accesses; the access goes to word addr[AW-1:1].
  - The rsp_err port remains and is tied to 0.

## Structure
- Package mau_pkg holds:
  - the state enum (IDLE, RD, WR, RSP)
  - lane constants LANE_LO=0 and LANE_HI=1
  - width constants AW and DW
- Sub-module mau_byte_lane (combinational) performs byte extract with sign/zero extend and byte merge, selected by addr[0].
- FSM and registered memory outputs live in the top level.

## Test plan
- Word store then load: store 0xBEEF at addr 0x0004, then load 0x0004.
  -> mem_we high for exactly 1 cycle with mem_a=0x0004; load rsp_data=0xBEEF at edge 2.
- Byte store, high lane: memory word 2 = 0x1234; byte store 0xAB at addr 0x0005.
  -> word 2 becomes 0xAB34; rsp_valid at edge 3.
- Byte loads: word 3 = 0x80FF.
  -> load addr 0x0007 with sext=1 gives 0xFF80.
  -> load addr 0x0006 with sext=0 gives 0x00FF.
- Response backpressure: rsp_ready held low for 5 cycles.
  -> rsp_valid and rsp_data stay stable; req_ready stays 0; the next request is accepted the cycle after rsp_ready.
- Reset mid-operation: assert rst_n=0 during WR of a byte store.
  -> mem_we drops immediately; no rsp_valid; after release req_ready=1 and state is IDLE.
- Misaligned word store to 0x0003:
  - with MAU_ALIGN_CHECK_EN: rsp_err=1 at edge 1; mem_we never asserted.
  - without MAU_ALIGN_CHECK_EN: word 1 is written.
